// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// reset PC, the NOP word shown while no instruction is valid, and PC stepping.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALTED = 2'd2,
    ST_ERROR  = 2'd3
  } fetch_state_t;

  localparam logic [15:0] DEF_RESET_PC  = 16'h0000;
  localparam logic [15:0] DEF_NOP_INSTR = 16'h0800;

  // 16-bit wrap from FFFE to 0000 is intended.
  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch control: state register, memory request generation and the latched
// address of a read that must be drained after a redirect.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        halt,
  input  logic        redirect,
  input  logic        redirect_odd,
  input  logic [15:0] pc,
  input  logic        mem_done,
  input  logic        mem_err,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic        resp,
  output logic        load_redirect,
  output logic        kill,
  output logic        halted,
  output logic        err
);

  fetch_state_t state;
  logic         pending;
  logic [15:0]  squash_addr;
  logic         active;
  logic         want;
  logic         halt_take;
  logic         fault;
  logic         misaligned;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    active     = (state == ST_FETCH) || (state == ST_SQUASH);
    want       = ~instr_valid | ~stall;
    halt_take  = halt & instr_valid & (state == ST_FETCH);
    mem_rd     = 1'b0;
    mem_addr   = pc;
    if (!rst) begin
      case (state)
        // An already-issued read stays up; only new requests are blocked.
        ST_FETCH:  mem_rd = ~halt_take & (pending | (want & ~halt & ~redirect));
        ST_SQUASH: begin
          mem_rd   = 1'b1;
          mem_addr = squash_addr;
        end
        default:   mem_rd = 1'b0;
      endcase
    end
    fault         = mem_rd & mem_done & mem_err;
    misaligned    = active & redirect & redirect_odd;
    resp          = (state == ST_FETCH) & mem_rd & mem_done & ~mem_err & ~redirect;
    kill          = active & (fault | redirect | halt_take);
    load_redirect = active & redirect & ~redirect_odd & ~fault & ~halt_take;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FETCH;
      pending     <= 1'b0;
      squash_addr <= '0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        ST_FETCH, ST_SQUASH: begin
          if (fault || misaligned) begin
            state   <= ST_ERROR;
            err     <= 1'b1;
            pending <= 1'b0;
          end else if (halt_take) begin
            state   <= ST_HALTED;
            halted  <= 1'b1;
            pending <= 1'b0;
          end else if (state == ST_FETCH) begin
            pending <= mem_rd & ~mem_done & ~redirect;
            if (redirect && mem_rd && !mem_done) begin
              state       <= ST_SQUASH;
              squash_addr <= pc;
            end
          end else if (mem_done) begin
            state   <= ST_FETCH;
            pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC and the Instr/PCPlus2/InstrValid
// registers presented to decode; request sequencing lives in fetch_ctrl.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [15:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  input  logic        mem_err,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  input  logic        Halt,
  output logic [15:0] Instr,
  output logic [15:0] PCPlus2,
  output logic        InstrValid,
  output logic        Halted,
  output logic        Err
);

  logic [15:0] pc;
  logic        resp;
  logic        load_redirect;
  logic        kill;
  logic        accept;

  assign accept = InstrValid & ~Stall;

  fetch_ctrl u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (InstrValid),
    .stall         (Stall),
    .halt          (Halt),
    .redirect      (Redirect),
    .redirect_odd  (RedirectPC[0]),
    .pc            (pc),
    .mem_done      (mem_done),
    .mem_err       (mem_err),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .resp          (resp),
    .load_redirect (load_redirect),
    .kill          (kill),
    .halted        (Halted),
    .err           (Err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      InstrValid <= 1'b0;
      Instr      <= NOP_INSTR;
      PCPlus2    <= '0;
    end else begin
      if (load_redirect) pc <= RedirectPC;
      else if (resp)     pc <= pc_inc(pc);

      // Instr reverts to NOP whenever the valid bit drops; PCPlus2 just holds.
      if (kill) begin
        InstrValid <= 1'b0;
        Instr      <= NOP_INSTR;
      end else if (resp) begin
        InstrValid <= 1'b1;
        Instr      <= mem_rdata;
        PCPlus2    <= pc_inc(pc);
      end else if (accept) begin
        InstrValid <= 1'b0;
        Instr      <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed vector table, a halted-hold sequence, then random
// stimulus checked against a cycle-level behavioural model of the stage.
module tb_fetch;

  localparam logic [15:0] NOP = 16'h0800;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic        v;
    logic [15:0] instr;
    logic [15:0] p2;
    logic        h;
    logic        e;
  } obs_t;

  typedef struct {
    logic        r, s, hl, d;
    logic [15:0] rpc;
    int          wt;
    logic [15:0] ea;
    obs_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, Stall, Halt, Redirect;
  logic [15:0] RedirectPC;
  logic        mem_rd, mem_done, mem_err;
  logic [15:0] mem_addr, mem_rdata;
  logic [15:0] Instr, PCPlus2;
  logic        InstrValid, Halted, Err;

  logic [15:0] mem [256];
  int          cnt = 0;
  int          mem_wait = 0;
  logic        err_bit = 1'b0;
  logic [15:0] err_addr = 16'h0001;

  int n_vec = 0;
  int n_bad = 0;

  // Model state
  logic [15:0] m_pc, m_instr, m_pcp2, m_sq_addr, m_addr;
  logic        m_valid, m_halted, m_err, m_squash, m_outst, m_req, m_done;

  vec_t tbl[34];

  always #5 clk = ~clk;

  // Memory: responds after mem_wait extra cycles; mem_wait=0 is same-cycle.
  assign mem_done  = mem_rd && (cnt >= mem_wait);
  assign mem_rdata = mem[mem_addr[8:1]];
  assign mem_err   = mem_done && (err_bit || (mem_addr == err_addr));

  always @(posedge clk) begin
    if (rst || !mem_rd || mem_done) cnt <= 0;
    else                            cnt <= cnt + 1;
  end

  fetch dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_done   (mem_done),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .Halt       (Halt),
    .Instr      (Instr),
    .PCPlus2    (PCPlus2),
    .InstrValid (InstrValid),
    .Halted     (Halted),
    .Err        (Err)
  );

  function automatic obs_t ob(input logic rd, input logic [15:0] a, input logic v,
                              input logic [15:0] ins, input logic [15:0] p2,
                              input logic h, input logic e);
    obs_t o;
    o.rd = rd; o.addr = a; o.v = v; o.instr = ins; o.p2 = p2; o.h = h; o.e = e;
    return o;
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic hl, input logic d,
                              input logic [15:0] rpc, input int wt, input logic [15:0] ea,
                              input obs_t exp);
    vec_t t;
    t.r = r; t.s = s; t.hl = hl; t.d = d; t.rpc = rpc; t.wt = wt; t.ea = ea; t.exp = exp;
    return t;
  endfunction

  function automatic obs_t sample();
    return ob(mem_rd, mem_rd ? mem_addr : 16'h0000, InstrValid, Instr, PCPlus2, Halted, Err);
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("rd=%0b addr=%h v=%0b instr=%h pcp2=%h halted=%0b err=%0b",
                     o.rd, o.addr, o.v, o.instr, o.p2, o.h, o.e);
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    rst = t.r; Stall = t.s; Halt = t.hl; Redirect = t.d; RedirectPC = t.rpc;
    mem_wait = t.wt; err_addr = t.ea; err_bit = 1'b0;
    #1;
    check($sformatf("vec%0d", idx), sample(), t.exp);
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = NOP; m_pcp2 = 16'h0000; m_sq_addr = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0; m_err = 1'b0; m_squash = 1'b0; m_outst = 1'b0;
  endtask

  task automatic model_drop();
    m_valid = 1'b0; m_instr = NOP; m_squash = 1'b0; m_outst = 1'b0;
  endtask

  // What the stage requests this cycle, from model state and current inputs.
  task automatic model_comb();
    m_addr = m_squash ? m_sq_addr : m_pc;
    if (rst || m_halted || m_err) m_req = 1'b0;
    else if (m_squash)            m_req = 1'b1;
    else m_req = m_outst || ((!m_valid || !Stall) && !Halt && !Redirect);
    m_done = m_req && (cnt >= mem_wait);
  endtask

  task automatic model_step();
    logic fault, mis;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_halted || m_err) return;
    fault = m_req && m_done && (err_bit || (m_addr == err_addr));
    mis   = Redirect && RedirectPC[0];
    if (fault || mis) begin
      m_err = 1'b1;
      model_drop();
    end else if (Halt && m_valid && !m_squash) begin
      m_halted = 1'b1;
      model_drop();
    end else if (m_squash) begin
      if (Redirect) m_pc = RedirectPC;
      if (m_done)   m_squash = 1'b0;
    end else if (Redirect) begin
      if (m_req && !m_done) begin
        m_squash  = 1'b1;
        m_sq_addr = m_pc;
      end
      m_pc = RedirectPC;
      m_valid = 1'b0; m_instr = NOP; m_outst = 1'b0;
    end else if (m_req && m_done) begin
      m_instr = mem[m_addr[8:1]];
      m_pcp2  = m_pc + 16'd2;
      m_pc    = m_pc + 16'd2;
      m_valid = 1'b1;
      m_outst = 1'b0;
    end else begin
      if (m_valid && !Stall) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
      m_outst = m_req;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i * 7);
    mem[0] = 16'hC005; mem[1] = 16'h0800; mem[8'h21] = 16'h0000;

    // Reset, zero-wait fetch, stall hold, squash on redirect, halt.
    tbl[0]  = mk(1,0,0,0,16'h0000,0,16'h0001, ob(0,16'h0000,0,NOP,16'h0000,0,0));
    tbl[1]  = mk(0,0,0,0,16'h0000,0,16'h0001, ob(1,16'h0000,0,NOP,16'h0000,0,0));
    tbl[2]  = mk(0,0,0,0,16'h0000,0,16'h0001, ob(1,16'h0002,1,16'hC005,16'h0002,0,0));
    tbl[3]  = mk(0,0,0,0,16'h0000,0,16'h0001, ob(1,16'h0004,1,16'h0800,16'h0004,0,0));
    tbl[4]  = mk(0,0,0,1,16'h0000,0,16'h0001, ob(0,16'h0000,1,16'h100E,16'h0006,0,0));
    tbl[5]  = mk(0,0,0,0,16'h0000,0,16'h0001, ob(1,16'h0000,0,NOP,16'h0006,0,0));
    tbl[6]  = mk(0,1,0,0,16'h0000,0,16'h0001, ob(0,16'h0000,1,16'hC005,16'h0002,0,0));
    tbl[7]  = mk(0,1,0,0,16'h0000,0,16'h0001, ob(0,16'h0000,1,16'hC005,16'h0002,0,0));
    tbl[8]  = mk(0,1,0,0,16'h0000,0,16'h0001, ob(0,16'h0000,1,16'hC005,16'h0002,0,0));
    tbl[9]  = mk(0,0,0,0,16'h0000,0,16'h0001, ob(1,16'h0002,1,16'hC005,16'h0002,0,0));
    tbl[10] = mk(0,0,0,0,16'h0000,2,16'h0001, ob(1,16'h0004,1,16'h0800,16'h0004,0,0));
    tbl[11] = mk(0,0,0,1,16'h0040,2,16'h0001, ob(1,16'h0004,0,NOP,16'h0004,0,0));
    tbl[12] = mk(0,0,0,0,16'h0000,2,16'h0001, ob(1,16'h0004,0,NOP,16'h0004,0,0));
    tbl[13] = mk(0,0,0,0,16'h0000,2,16'h0001, ob(1,16'h0040,0,NOP,16'h0004,0,0));
    tbl[14] = mk(0,0,0,0,16'h0000,2,16'h0001, ob(1,16'h0040,0,NOP,16'h0004,0,0));
    tbl[15] = mk(0,0,0,0,16'h0000,2,16'h0001, ob(1,16'h0040,0,NOP,16'h0004,0,0));
    tbl[16] = mk(0,0,0,0,16'h0000,0,16'h0001, ob(1,16'h0042,1,16'h10E0,16'h0042,0,0));
    tbl[17] = mk(0,0,1,0,16'h0000,0,16'h0001, ob(0,16'h0000,1,16'h0000,16'h0044,0,0));
    tbl[18] = mk(0,0,0,0,16'h0000,0,16'h0001, ob(0,16'h0000,0,NOP,16'h0044,1,0));
    // Memory fault at 6, misaligned redirect, PC wrap.
    tbl[19] = mk(1,0,0,0,16'h0000,0,16'h0001, ob(0,16'h0000,0,NOP,16'h0044,1,0));
    tbl[20] = mk(0,0,0,0,16'h0000,0,16'h0006, ob(1,16'h0000,0,NOP,16'h0000,0,0));
    tbl[21] = mk(0,0,0,0,16'h0000,0,16'h0006, ob(1,16'h0002,1,16'hC005,16'h0002,0,0));
    tbl[22] = mk(0,0,0,0,16'h0000,0,16'h0006, ob(1,16'h0004,1,16'h0800,16'h0004,0,0));
    tbl[23] = mk(0,0,0,0,16'h0000,0,16'h0006, ob(1,16'h0006,1,16'h100E,16'h0006,0,0));
    tbl[24] = mk(0,0,0,0,16'h0000,0,16'h0006, ob(0,16'h0000,0,NOP,16'h0006,0,1));
    tbl[25] = mk(0,0,0,1,16'h0010,0,16'h0006, ob(0,16'h0000,0,NOP,16'h0006,0,1));
    tbl[26] = mk(1,0,0,0,16'h0000,0,16'h0001, ob(0,16'h0000,0,NOP,16'h0006,0,1));
    tbl[27] = mk(0,0,0,0,16'h0000,0,16'h0001, ob(1,16'h0000,0,NOP,16'h0000,0,0));
    tbl[28] = mk(0,0,0,1,16'h0013,0,16'h0001, ob(0,16'h0000,1,16'hC005,16'h0002,0,0));
    tbl[29] = mk(0,0,0,0,16'h0000,0,16'h0001, ob(0,16'h0000,0,NOP,16'h0002,0,1));
    tbl[30] = mk(1,0,0,0,16'h0000,0,16'h0001, ob(0,16'h0000,0,NOP,16'h0002,0,1));
    tbl[31] = mk(0,0,0,1,16'hFFFE,0,16'h0001, ob(0,16'h0000,0,NOP,16'h0000,0,0));
    tbl[32] = mk(0,0,0,0,16'h0000,0,16'h0001, ob(1,16'hFFFE,0,NOP,16'h0000,0,0));
    tbl[33] = mk(0,0,0,0,16'h0000,0,16'h0001, ob(1,16'h0000,1,16'h16F9,16'h0000,0,0));

    rst = 1'b1; Stall = 1'b0; Halt = 1'b0; Redirect = 1'b0; RedirectPC = 16'h0000;
    repeat (2) @(negedge clk);

    for (int i = 0; i <= 18; i++) apply(tbl[i], i);

    // Once halted, nothing but reset may restart fetching.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      Stall = 1'($urandom_range(1));
      Redirect = 1'($urandom_range(1));
      r = 16'($urandom);
      r[0] = 1'b0;
      RedirectPC = r;
      #1;
      check($sformatf("halted_hold%0d", i), sample(), ob(0,16'h0000,0,NOP,16'h0044,1,0));
    end

    for (int i = 19; i < 34; i++) apply(tbl[i], i);

    // Random phase against the behavioural model.
    @(negedge clk);
    rst = 1'b1; Stall = 1'b0; Halt = 1'b0; Redirect = 1'b0;
    mem_wait = 0; err_bit = 1'b0; err_addr = 16'h0001;
    repeat (2) @(negedge clk);
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((m_halted || m_err) && $urandom_range(9) == 0) rst = 1'b1;
      else rst = ($urandom_range(199) == 0);
      Stall    = ($urandom_range(9) < 3);
      Halt     = ($urandom_range(49) == 0);
      Redirect = ($urandom_range(19) == 0);
      r = 16'($urandom);
      if ($urandom_range(7) != 0) r[0] = 1'b0;
      RedirectPC = r;
      mem_wait = $urandom_range(2);
      err_bit  = ($urandom_range(99) == 0);
      #1;
      model_comb();
      check($sformatf("rand%0d", i), sample(),
            ob(m_req, m_req ? m_addr : 16'h0000, m_valid, m_instr, m_pcp2, m_halted, m_err));
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
